// File: rtl/jvo_pulse_pkg.sv
// Shared constants, state encoding and word type for the double-buffered pulse-timing table.
package jvo_pulse_pkg;
    localparam int N_CH_DEF  = 20;
    localparam int CW_DEF    = 32;
    localparam int ADDR_BEG0 = 0;
    localparam int ADDR_END0 = N_CH_DEF;
    localparam int ADDR_INIT = 2 * N_CH_DEF;
    localparam int ADDR_MAX  = 2 * N_CH_DEF + 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CHECK     = 2'd1,
        WAIT_WRAP = 2'd2
    } pt_state_e;

    typedef logic [CW_DEF-1:0] cnt_t;
endpackage

// File: rtl/jvo_pt_checker.sv
// Per-channel timing rule: fails on beg == end or either count beyond max.
// An all-ones beg/end pair marks an unused channel and always passes.
module jvo_pt_checker #(
    parameter int CW = 32
) (
    input  logic [CW-1:0] beg_i,
    input  logic [CW-1:0] end_i,
    input  logic [CW-1:0] max_i,
    output logic          fail_o
);
    logic unused_ch;

    assign unused_ch = (beg_i == '1) && (end_i == '1);
    assign fail_o    = !unused_ch &&
                       ((beg_i == end_i) || (beg_i > max_i) || (end_i > max_i));
endmodule

// File: rtl/jvo_pulse_table.sv
// Shadow/active pulse table: software fills the shadow, a commit validates it and swaps at sequence wrap.
// Optional registered readback of the active table when JVO_PULSE_TABLE_READBACK_EN is defined.
module jvo_pulse_table
    import jvo_pulse_pkg::*;
#(
    parameter int N_CH = N_CH_DEF,
    parameter int CW   = CW_DEF,
    parameter int AW   = 6
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               wr_valid_i,
    output logic               wr_ready_o,
    input  logic [AW-1:0]      wr_addr_i,
    input  logic [CW-1:0]      wr_data_i,
    input  logic               commit_req_i,
    input  logic               commit_abort_i,
    input  logic               running_i,
    input  logic               seq_wrap_i,
`ifdef JVO_PULSE_TABLE_READBACK_EN
    input  logic [AW-1:0]      rd_addr_i,
    output logic [CW-1:0]      rd_data_o,
`endif
    output logic [N_CH*CW-1:0] cnt_beg_o,
    output logic [N_CH*CW-1:0] cnt_end_o,
    output logic [CW-1:0]      io_init_o,
    output logic [CW-1:0]      max_count_o,
    output logic               busy_o,
    output logic               applied_o,
    output logic [1:0]         err_o
);
    localparam int IW      = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int A_END0  = ADDR_BEG0 + N_CH;
    localparam int A_INIT  = ADDR_BEG0 + 2 * N_CH;
    localparam int A_MAX   = ADDR_BEG0 + 2 * N_CH + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N_CH - 1);

    pt_state_e state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          fail_q, fail_d;
    logic [1:0]    err_q, err_d;
    logic          applied_q;
    logic          do_copy;

    logic [N_CH-1:0][CW-1:0] sh_beg_q, sh_end_q, act_beg_q, act_end_q;
    logic [CW-1:0]           sh_init_q, sh_max_q, act_init_q, act_max_q;

    logic wr_fire, wr_unmapped, chk_fail;

    assign wr_ready_o  = (state_q == IDLE);
    assign wr_fire     = wr_valid_i && wr_ready_o;
    assign wr_unmapped = (wr_addr_i > AW'(A_MAX));

    jvo_pt_checker #(.CW(CW)) u_checker (
        .beg_i  (sh_beg_q[idx_q]),
        .end_i  (sh_end_q[idx_q]),
        .max_i  (sh_max_q),
        .fail_o (chk_fail)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        fail_d  = fail_q;
        err_d   = err_q;
        do_copy = 1'b0;
        case (state_q)
            IDLE: begin
                if (commit_req_i) begin
                    err_d   = 2'b00;
                    idx_d   = '0;
                    fail_d  = 1'b0;
                    state_d = CHECK;
                end
                if (wr_fire && wr_unmapped) err_d[0] = 1'b1;
            end
            CHECK: begin
                fail_d = fail_q | chk_fail | (sh_max_q == '0);
                idx_d  = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    idx_d = '0;
                    if (fail_d) begin
                        err_d[1] = 1'b1;
                        state_d  = IDLE;
                    end else if (!running_i) begin
                        do_copy = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT_WRAP;
                    end
                end
            end
            WAIT_WRAP: begin
                // Abort outranks a wrap arriving in the same cycle.
                if (commit_abort_i) begin
                    state_d = IDLE;
                end else if (seq_wrap_i || !running_i) begin
                    do_copy = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            fail_q    <= 1'b0;
            err_q     <= 2'b00;
            applied_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            fail_q    <= fail_d;
            err_q     <= err_d;
            applied_q <= do_copy;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sh_beg_q  <= '0;
            sh_end_q  <= '0;
            sh_init_q <= '0;
            sh_max_q  <= '0;
        end else if (wr_fire) begin
            for (int i = 0; i < N_CH; i++) begin
                if (wr_addr_i == AW'(ADDR_BEG0 + i)) sh_beg_q[i] <= wr_data_i;
                if (wr_addr_i == AW'(A_END0 + i))    sh_end_q[i] <= wr_data_i;
            end
            if (wr_addr_i == AW'(A_INIT)) sh_init_q <= wr_data_i;
            if (wr_addr_i == AW'(A_MAX))  sh_max_q  <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            act_beg_q  <= '0;
            act_end_q  <= '0;
            act_init_q <= '0;
            act_max_q  <= '0;
        end else if (do_copy) begin
            act_beg_q  <= sh_beg_q;
            act_end_q  <= sh_end_q;
            act_init_q <= sh_init_q;
            act_max_q  <= sh_max_q;
        end
    end

    assign cnt_beg_o   = act_beg_q;
    assign cnt_end_o   = act_end_q;
    assign io_init_o   = act_init_q;
    assign max_count_o = act_max_q;
    assign busy_o      = (state_q != IDLE);
    assign applied_o   = applied_q;
    assign err_o       = err_q;

`ifdef JVO_PULSE_TABLE_READBACK_EN
    logic [CW-1:0] rd_data_q, rd_data_d;

    always_comb begin
        rd_data_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (rd_addr_i == AW'(ADDR_BEG0 + i)) rd_data_d = act_beg_q[i];
            if (rd_addr_i == AW'(A_END0 + i))    rd_data_d = act_end_q[i];
        end
        if (rd_addr_i == AW'(A_INIT)) rd_data_d = act_init_q;
        if (rd_addr_i == AW'(A_MAX))  rd_data_d = act_max_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) rd_data_q <= '0;
        else       rd_data_q <= rd_data_d;
    end

    assign rd_data_o = rd_data_q;
`endif
endmodule

// File: tb/tb_jvo_pulse_table.sv
// Directed plus randomized bench for jvo_pulse_table against a table-level reference model.
module tb_jvo_pulse_table;
    import jvo_pulse_pkg::*;

    localparam int N  = N_CH_DEF;
    localparam int CW = CW_DEF;
    localparam int AW = 6;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              wr_valid_i = 1'b0;
    logic              wr_ready_o;
    logic [AW-1:0]     wr_addr_i = '0;
    logic [CW-1:0]     wr_data_i = '0;
    logic              commit_req_i = 1'b0;
    logic              commit_abort_i = 1'b0;
    logic              running_i = 1'b0;
    logic              seq_wrap_i = 1'b0;
    logic [N*CW-1:0]   cnt_beg_o, cnt_end_o;
    logic [CW-1:0]     io_init_o, max_count_o;
    logic              busy_o, applied_o;
    logic [1:0]        err_o;
`ifdef JVO_PULSE_TABLE_READBACK_EN
    logic [AW-1:0]     rd_addr_i = '0;
    logic [CW-1:0]     rd_data_o;
`endif

    jvo_pulse_table dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .wr_valid_i     (wr_valid_i),
        .wr_ready_o     (wr_ready_o),
        .wr_addr_i      (wr_addr_i),
        .wr_data_i      (wr_data_i),
        .commit_req_i   (commit_req_i),
        .commit_abort_i (commit_abort_i),
        .running_i      (running_i),
        .seq_wrap_i     (seq_wrap_i),
`ifdef JVO_PULSE_TABLE_READBACK_EN
        .rd_addr_i      (rd_addr_i),
        .rd_data_o      (rd_data_o),
`endif
        .cnt_beg_o      (cnt_beg_o),
        .cnt_end_o      (cnt_end_o),
        .io_init_o      (io_init_o),
        .max_count_o    (max_count_o),
        .busy_o         (busy_o),
        .applied_o      (applied_o),
        .err_o          (err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    cnt_t       m_sh_beg[N], m_sh_end[N], m_act_beg[N], m_act_end[N];
    cnt_t       m_sh_init, m_sh_max, m_act_init, m_act_max;
    logic [1:0] m_err;

    cnt_t rb, re, rmx;
    int   kind, bad_ch;
    bit   rrun;

    task automatic step();
        @(negedge clk_i);
    endtask

    task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        for (int i = 0; i < N; i++) begin
            chk({tag, "_beg"}, cnt_beg_o[i*CW +: CW], m_act_beg[i]);
            chk({tag, "_end"}, cnt_end_o[i*CW +: CW], m_act_end[i]);
        end
        chk({tag, "_init"}, io_init_o, m_act_init);
        chk({tag, "_max"}, max_count_o, m_act_max);
        chk({tag, "_err"}, {30'd0, err_o}, {30'd0, m_err});
    endtask

    function automatic void m_reset();
        for (int i = 0; i < N; i++) begin
            m_sh_beg[i] = '0; m_sh_end[i] = '0; m_act_beg[i] = '0; m_act_end[i] = '0;
        end
        m_sh_init = '0; m_sh_max = '0; m_act_init = '0; m_act_max = '0;
        m_err = 2'b00;
    endfunction

    function automatic void m_write(input int a, input cnt_t d);
        if (a < N)              m_sh_beg[a] = d;
        else if (a < 2*N)       m_sh_end[a-N] = d;
        else if (a == ADDR_INIT) m_sh_init = d;
        else if (a == ADDR_MAX)  m_sh_max = d;
        else                     m_err[0] = 1'b1;
    endfunction

    function automatic bit m_valid();
        if (m_sh_max == 0) return 1'b0;
        for (int i = 0; i < N; i++) begin
            if (m_sh_beg[i] == 32'hFFFF_FFFF && m_sh_end[i] == 32'hFFFF_FFFF) continue;
            if (m_sh_beg[i] == m_sh_end[i]) return 1'b0;
            if (m_sh_beg[i] > m_sh_max || m_sh_end[i] > m_sh_max) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void m_apply();
        m_act_beg = m_sh_beg; m_act_end = m_sh_end;
        m_act_init = m_sh_init; m_act_max = m_sh_max;
    endfunction

    task automatic wr(input int a, input cnt_t d);
        wr_valid_i = 1'b1; wr_addr_i = AW'(a); wr_data_i = d;
        chk("wr_ready_idle", {31'd0, wr_ready_o}, 1);
        step();
        wr_valid_i = 1'b0;
        m_write(a, d);
    endtask

    // mode: 0 = seq_wrap, 1 = abort then wrap, 2 = running falls
    task automatic commit_seq(input bit run, input int mode, input int wait_n);
        bit pass;
        running_i = run;
        commit_req_i = 1'b1;
        m_err = 2'b00;
        if (wr_valid_i) m_write(int'(wr_addr_i), wr_data_i);
        step();
        commit_req_i = 1'b0;
        pass = m_valid();
        for (int c = 0; c < N - 1; c++) begin
            step();
            chk("busy_check", {31'd0, busy_o}, 1);
            chk("rdy_check", {31'd0, wr_ready_o}, 0);
            chk("applied_check", {31'd0, applied_o}, 0);
        end
        chk_all("pre_decision");
        step();
        if (!pass) begin
            m_err[1] = 1'b1;
            chk("applied_fail", {31'd0, applied_o}, 0);
            chk("busy_fail", {31'd0, busy_o}, 0);
        end else if (!run) begin
            m_apply();
            chk("applied_idle", {31'd0, applied_o}, 1);
            chk("busy_idle", {31'd0, busy_o}, 0);
        end else begin
            chk("busy_wait", {31'd0, busy_o}, 1);
            chk("applied_wait", {31'd0, applied_o}, 0);
            for (int w = 0; w < wait_n; w++) begin
                step();
                chk("busy_wait_n", {31'd0, busy_o}, 1);
                chk("rdy_wait_n", {31'd0, wr_ready_o}, 0);
            end
            if (mode == 0) seq_wrap_i = 1'b1;
            else if (mode == 1) commit_abort_i = 1'b1;
            else running_i = 1'b0;
            chk_all("before_edge");
            step();
            seq_wrap_i = 1'b0; commit_abort_i = 1'b0;
            if (mode != 1) begin
                m_apply();
                chk("applied_wrap", {31'd0, applied_o}, 1);
            end else begin
                chk("applied_abort", {31'd0, applied_o}, 0);
            end
            chk("busy_after", {31'd0, busy_o}, 0);
            if (mode == 1) begin
                chk_all("after_abort");
                seq_wrap_i = 1'b1;
                step();
                seq_wrap_i = 1'b0;
                chk("applied_late_wrap", {31'd0, applied_o}, 0);
            end
        end
        chk_all("after_commit");
        step();
        chk("applied_one_cycle", {31'd0, applied_o}, 0);
        running_i = 1'b0;
    endtask

    initial begin
        m_reset();
        step(); step();
        chk_all("reset");
        chk("reset_busy", {31'd0, busy_o}, 0);
        chk("reset_applied", {31'd0, applied_o}, 0);
        chk("reset_ready", {31'd0, wr_ready_o}, 1);
        rst_i = 1'b0;
        step();

        // Basic apply while idle; unused channels marked all-ones.
        for (int i = 1; i < N; i++) begin
            wr(ADDR_BEG0 + i, 32'hFFFF_FFFF);
            wr(ADDR_END0 + i, 32'hFFFF_FFFF);
        end
        wr(ADDR_BEG0, 5); wr(ADDR_END0, 9); wr(ADDR_MAX, 99);
        commit_seq(1'b0, 0, 0);
        chk("t1_beg0", cnt_beg_o[CW-1:0], 5);

        // Apply at wrap while running.
        wr(ADDR_INIT, 32'h000A_5A5A);
        commit_seq(1'b1, 0, 5);

        // beg == end fails, all-ones pair passes.
        wr(ADDR_BEG0 + 3, 7); wr(ADDR_END0 + 3, 7);
        commit_seq(1'b0, 0, 0);
        wr(ADDR_BEG0 + 3, 32'hFFFF_FFFF); wr(ADDR_END0 + 3, 32'hFFFF_FFFF);
        commit_seq(1'b0, 0, 0);

        // max_count of zero fails.
        wr(ADDR_MAX, 0);
        commit_seq(1'b0, 0, 0);
        wr(ADDR_MAX, 99);

        // Unmapped write sets err[0]; write held through CHECK.
        wr(50, 32'h1234);
        chk("unmapped_err", {30'd0, err_o}, {30'd0, m_err});
        wr_valid_i = 1'b1; wr_addr_i = AW'(ADDR_INIT); wr_data_i = 32'h0000_0F0F;
        commit_seq(1'b0, 0, 0);
        chk("held_ready_idle", {31'd0, wr_ready_o}, 1);
        step();
        wr_valid_i = 1'b0;

        // Abort in WAIT_WRAP and running falling.
        wr(ADDR_END0, 40);
        commit_seq(1'b1, 1, 2);
        commit_seq(1'b1, 2, 3);

        // Async reset during CHECK.
        wr(ADDR_BEG0 + 7, 11); wr(ADDR_END0 + 7, 22);
        commit_req_i = 1'b1;
        step();
        commit_req_i = 1'b0;
        step(); step(); step();
        rst_i = 1'b1;
        #1;
        m_reset();
        chk_all("async_rst");
        chk("async_rst_busy", {31'd0, busy_o}, 0);
        chk("async_rst_applied", {31'd0, applied_o}, 0);
        step();
        rst_i = 1'b0;
        step();

        // Randomized tables.
        for (int r = 0; r < 10; r++) begin
            rmx = cnt_t'($urandom_range(10, 5000));
            for (int i = 0; i < N; i++) begin
                kind = $urandom_range(0, 5);
                if (kind == 0) begin
                    rb = '1; re = '1;
                end else begin
                    rb = cnt_t'($urandom_range(0, int'(rmx) - 1));
                    re = cnt_t'($urandom_range(int'(rb) + 1, int'(rmx)));
                    if (kind == 1) begin rb = rb ^ re; re = rb ^ re; rb = rb ^ re; end
                end
                if (r % 2 == 1 && i == 0) bad_ch = $urandom_range(0, N - 1);
                if (r % 2 == 1 && i == bad_ch) begin
                    if (kind < 3) re = rb;
                    else re = rmx + cnt_t'($urandom_range(1, 100));
                end
                wr(ADDR_BEG0 + i, rb);
                wr(ADDR_END0 + i, re);
            end
            wr(ADDR_INIT, cnt_t'($urandom_range(0, (1 << N) - 1)));
            wr(ADDR_MAX, rmx);
            rrun = 1'($urandom_range(0, 1));
            commit_seq(rrun, $urandom_range(0, 2), $urandom_range(0, 6));
        end

`ifdef JVO_PULSE_TABLE_READBACK_EN
        rd_addr_i = AW'(ADDR_MAX);
        step();
        chk("rd_max", rd_data_o, m_act_max);
        rd_addr_i = AW'(ADDR_END0 + 4);
        step();
        chk("rd_end4", rd_data_o, m_act_end[4]);
        rd_addr_i = AW'(60);
        step();
        chk("rd_unmapped", rd_data_o, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
